// File: rtl/eth_pcs_rx_gearbox.sv
// eth_pcs_rx_gearbox: 10GBASE-R receive 32-to-66 gearbox.
// Packs 32-bit PMA words into 66-bit blocks and emits each block as a sync
// header plus two 32-bit transfers. Bit slips realign block boundaries.
// Optional feature macro: ETH_PCS_RX_BLOCK_LOCK_EN (internal block-lock FSM
// drives slips and i_slip is ignored; otherwise o_block_lock is held at 1).
module eth_pcs_rx_gearbox #(
  parameter int W_DATA        = 32,
  parameter int W_SYNC        = 2,
  parameter int LOCK_GOOD_CNT = 64,
  parameter int LOCK_BAD_CNT  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [W_DATA-1:0] i_pma_data,
  input  logic              i_slip,
  output logic              o_valid,
  output logic [W_SYNC-1:0] o_sync_hdr,
  output logic [W_DATA-1:0] o_data,
  output logic              o_trans_cnt,
  output logic              o_block_lock
);

  localparam int BUF_W = 3 * W_DATA;
  localparam int CNT_W = $clog2(BUF_W + 1);

  logic [BUF_W-1:0]  buf_q, buf_d, buf_app, buf_slp, fill_mask;
  logic [CNT_W-1:0]  cnt_q, cnt_d, avail, need;
  logic              ph_q;
  logic              valid_q, tc_q, lock_q;
  logic [W_SYNC-1:0] hdr_q, hdr_d;
  logic [W_DATA-1:0] data_q, data_d;
  logic              slip_act;
  logic              emit;

  // Append the new word, apply an optional one-bit slip, and extract a transfer
  always_comb begin
    fill_mask = ~({BUF_W{1'b1}} << cnt_q);
    buf_app   = (buf_q & fill_mask) | ({{(BUF_W-W_DATA){1'b0}}, i_pma_data} << cnt_q);
    avail     = cnt_q + CNT_W'(W_DATA);
    buf_slp   = buf_app;
    if (slip_act) begin
      buf_slp = buf_app >> 1;
      avail   = avail - CNT_W'(1);
    end
    need   = ph_q ? CNT_W'(W_DATA) : CNT_W'(W_DATA + W_SYNC);
    emit   = (avail >= need);
    hdr_d  = buf_slp[W_SYNC-1:0];
    data_d = ph_q ? buf_slp[W_DATA-1:0] : buf_slp[W_SYNC +: W_DATA];
    buf_d  = buf_slp;
    cnt_d  = avail;
    if (emit) begin
      buf_d = buf_slp >> need;
      cnt_d = avail - need;
    end
  end

  // Bit buffer, fill count, block phase and registered transfer outputs
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      ph_q    <= 1'b0;
      valid_q <= 1'b0;
      tc_q    <= 1'b0;
      hdr_q   <= '0;
      data_q  <= '0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      valid_q <= emit;
      if (emit) begin
        data_q <= data_d;
        tc_q   <= ph_q;
        ph_q   <= ~ph_q;
        if (!ph_q) hdr_q <= hdr_d;
      end
    end
  end

`ifdef ETH_PCS_RX_BLOCK_LOCK_EN
  localparam int GOOD_W  = $clog2(LOCK_GOOD_CNT + 1);
  localparam int BAD_W   = $clog2(LOCK_BAD_CNT + 1);
  localparam int WIN_LEN = 64;
  localparam int WIN_W   = $clog2(WIN_LEN);

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} lock_state_t;

  lock_state_t      state_q;
  logic [GOOD_W-1:0] good_q;
  logic [BAD_W-1:0]  bad_q;
  logic [WIN_W-1:0]  win_q;
  logic              slip_q;
  logic              hdr_chk, hdr_ok;
  logic              unused_slip;

  assign unused_slip = i_slip;
  assign slip_act    = slip_q;
  assign hdr_chk     = emit && !ph_q;
  assign hdr_ok      = (hdr_d == W_SYNC'(1)) || (hdr_d == W_SYNC'(2));

  // Block-lock FSM: hunt by slipping on bad headers, drop lock on too many bad per window
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_UNLOCKED;
      good_q  <= '0;
      bad_q   <= '0;
      win_q   <= '0;
      slip_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      slip_q <= 1'b0;
      if (hdr_chk) begin
        case (state_q)
          ST_UNLOCKED: begin
            if (hdr_ok) begin
              if (good_q == GOOD_W'(LOCK_GOOD_CNT - 1)) begin
                state_q <= ST_LOCKED;
                lock_q  <= 1'b1;
                good_q  <= '0;
                bad_q   <= '0;
                win_q   <= '0;
              end else begin
                good_q <= good_q + GOOD_W'(1);
              end
            end else begin
              slip_q <= 1'b1;
              good_q <= '0;
            end
          end
          ST_LOCKED: begin
            if (!hdr_ok && (bad_q == BAD_W'(LOCK_BAD_CNT - 1))) begin
              state_q <= ST_UNLOCKED;
              lock_q  <= 1'b0;
              slip_q  <= 1'b1;
              good_q  <= '0;
              bad_q   <= '0;
              win_q   <= '0;
            end else if (win_q == WIN_W'(WIN_LEN - 1)) begin
              bad_q <= '0;
              win_q <= '0;
            end else begin
              win_q <= win_q + WIN_W'(1);
              if (!hdr_ok) bad_q <= bad_q + BAD_W'(1);
            end
          end
          default: state_q <= ST_UNLOCKED;
        endcase
      end
    end
  end
`else
  assign slip_act = i_slip;

  // Without the lock FSM the block is always reported as locked once out of reset
  always_ff @(posedge i_clk) begin
    if (!i_reset) lock_q <= 1'b0;
    else          lock_q <= 1'b1;
  end
`endif

  assign o_valid      = valid_q;
  assign o_sync_hdr   = hdr_q;
  assign o_data       = data_q;
  assign o_trans_cnt  = tc_q;
  assign o_block_lock = lock_q;

endmodule
